wm8731_i2c_responder: RTL and testbench
=======================================

WM8731_I2C_RESPONDER -- requirements
Module: wm8731_i2c_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address answered (write byte 0x34).
REQ-002 Parameter FILT_CYCLES, default 4, number of consecutive equal CLOCK_50 samples required to accept a new SCL/SDA level.
REQ-003 CLOCK_50  in  1  single system clock; all logic on rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 I2C_SCLK  in  1  I2C clock from the initiator.
REQ-006 I2C_SDAT_IN  in  1  sampled level of the shared SDA line.
REQ-007 SDO  out  1  open-drain control; 0 = pull SDA low, 1 = release.
REQ-008 wr_valid  out  1  one-cycle strobe, register write committed.
REQ-009 wr_addr  out  7  register address of the committed write.
REQ-010 wr_data  out  9  register data of the committed write.
REQ-011 rd_addr  in  4  register-file read index.
REQ-012 rd_data  out  9  combinational read of register rd_addr; 0 for unimplemented indices.
REQ-013 busy  out  1  high from accepted START to STOP.

Function
REQ-014 SCL/SDA pass a 2-flop synchronizer then the FILT_CYCLES glitch filter; edges are detected on filtered levels only.
REQ-015 START = filtered SDA falls while SCL high; STOP = SDA rises while SCL high; both are honoured in every state.
REQ-016 FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-017 IDLE->ADDR on START; ADDR shifts 8 bits MSB first on SCL rising edges.
REQ-018 After the 8th bit: if bits[7:1]==DEV_ADDR and bit0==0, go ACK_A; otherwise go IGNORE with SDO held 1.
REQ-019 ACK: SDO driven 0 from the SCL falling edge after the 8th bit to the next SCL falling edge, then released.
REQ-020 BYTE1 = {reg_addr[6:0], data[8]}; BYTE2 = data[7:0]; each byte is ACKed in ACK_1/ACK_2.
REQ-021 Commit occurs at the SCL falling edge that starts ACK_2: wr_valid pulses for one cycle; wr_addr/wr_data hold until the next commit.
REQ-022 The register file holds indices 0-9 and 15; a write to any other address is ACKed, pulses wr_valid, and leaves the file unchanged.
REQ-023 Any byte after BYTE2 is NACKed (SDO stays 1) and the FSM moves to IGNORE.
REQ-024 IGNORE holds SDO=1 until START (->ADDR) or STOP (->IDLE).
REQ-025 Repeated START in any state restarts ADDR; a partial transaction is discarded with no commit.
REQ-026 STOP before ACK_2 discards the transaction; the file is unchanged and there is no wr_valid.
REQ-027 SDO never changes while filtered SCL is high.

Reset
REQ-028 RESET asserted: state=IDLE, SDO=1, busy=0, wr_valid=0, wr_addr=0, wr_data=0, shift register cleared.
REQ-029 Reset register values: R0=0x097 R1=0x097 R2=0x079 R3=0x079 R4=0x00A R5=0x008 R6=0x09F R7=0x00A R8=0x000 R9=0x000 R15=0x000.
REQ-030 RESET mid-transaction releases SDA within one clock; the bus stays IDLE until a fresh START.

Configuration
REQ-031 Macro WM8731_SOFT_RESET_REG_EN defined: a commit to address 0x0F with any data restores all registers to the REQ-029 values in the commit cycle; wr_valid still pulses.
REQ-032 Macro WM8731_SOFT_RESET_REG_EN undefined: address 0x0F is stored as an ordinary register.

Verification
REQ-033 START, 0x34, 0x0C, 0x00, STOP -> three ACKs, wr_valid once, wr_addr=0x06, wr_data=0x000, rd_addr=6 reads 0x000.
REQ-034 START, 0x36, ... -> no ACK on any byte, no wr_valid, registers unchanged.
REQ-035 START, 0x34, 0x08, repeated START, 0x34, 0x09, 0x55, STOP -> one commit only, addr 0x04, data 0x155.
REQ-036 A 2-cycle SCL glitch during BYTE1 with FILT_CYCLES=4 -> no extra bit shifted; the correct value is stored.
REQ-037 Write R4=0x1FF, then write 0x1E (addr 0x0F) -> with the macro defined, R4 reads 0x00A; without it, R4 stays 0x1FF and R15 reads 0x000.
REQ-038 RESET pulsed during ACK_1 -> SDO=1 the next cycle, busy=0, no commit, R0 reads 0x097.

Source files
------------

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: write-only I2C target emulating the WM8731 control port and register file.
// Optional macro WM8731_SOFT_RESET_REG_EN: a commit to register 0x0F restores every register default.
module wm8731_i2c_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         FILT_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    input  logic       I2C_SDAT_IN,
    output logic       SDO,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;
    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [8:0] RST_VAL [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008,
                                            9'h09F, 9'h00A, 9'h000, 9'h000, 9'h000, 9'h000,
                                            9'h000, 9'h000, 9'h000, 9'h000};

    logic [1:0]    w_raw, r_s1, r_s2, r_f, r_p;
    logic [CW-1:0] r_cnt [2];
    state_t        r_state;
    logic [7:0]    r_shift, r_byte1;
    logic [3:0]    r_bits;
    logic          r_sdo, r_busy, r_wr_valid;
    logic [6:0]    r_wr_addr;
    logic [8:0]    r_wr_data;
    logic [8:0]    r_regs [16];
    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_commit, w_wimpl, w_rimpl;
    logic [6:0]    w_waddr;
    logic [8:0]    w_wdata;

    // bit 1 carries SCL, bit 0 carries SDA through the synchronizer and filter
    assign w_raw = {I2C_SCLK, I2C_SDAT_IN};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_s1     <= '1;
            r_s2     <= '1;
            r_f      <= '1;
            r_p      <= '1;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            r_p  <= r_f;
            for (int c = 0; c < 2; c++)
                if (r_s2[c] == r_f[c]) r_cnt[c] <= '0;
                else if (r_cnt[c] == CW'(FILT_CYCLES - 1)) begin
                    r_f[c]   <= r_s2[c];
                    r_cnt[c] <= '0;
                end else r_cnt[c] <= r_cnt[c] + 1'b1;
        end
    end

    assign w_scl_rise = r_f[1] & ~r_p[1];
    assign w_scl_fall = ~r_f[1] & r_p[1];
    assign w_start    = r_f[1] & r_p[1] & r_p[0] & ~r_f[0];
    assign w_stop     = r_f[1] & r_p[1] & ~r_p[0] & r_f[0];
    assign w_commit   = (r_state == BYTE2) & w_scl_fall & (r_bits == 4'd8);
    assign w_waddr    = r_byte1[7:1];
    assign w_wdata    = {r_byte1[0], r_shift};
    assign w_wimpl    = (w_waddr <= 7'd9) | (w_waddr == 7'd15);
    assign w_rimpl    = (rd_addr <= 4'd9) | (rd_addr == 4'd15);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_byte1    <= '0;
            r_bits     <= '0;
            r_sdo      <= 1'b1;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= w_commit;
            if (w_commit) begin
                r_wr_addr <= w_waddr;
                r_wr_data <= w_wdata;
            end
            if (w_start) begin
                r_state <= ADDR;
                r_bits  <= '0;
                r_shift <= '0;
                r_sdo   <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_stop) begin
                r_state <= IDLE;
                r_sdo   <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_scl_rise && (r_state == ADDR || r_state == BYTE1 || r_state == BYTE2)) begin
                r_shift <= {r_shift[6:0], r_f[0]};
                r_bits  <= r_bits + 4'd1;
            end else if (w_scl_fall) begin
                // SDO only moves on filtered SCL falling edges so it is stable while SCL is high
                case (r_state)
                    ADDR: if (r_bits == 4'd8) begin
                        r_state <= (r_shift == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                        r_sdo   <= r_shift != {DEV_ADDR, 1'b0};
                    end
                    ACK_A: begin
                        r_state <= BYTE1;
                        r_sdo   <= 1'b1;
                        r_bits  <= '0;
                    end
                    BYTE1: if (r_bits == 4'd8) begin
                        r_byte1 <= r_shift;
                        r_state <= ACK_1;
                        r_sdo   <= 1'b0;
                    end
                    ACK_1: begin
                        r_state <= BYTE2;
                        r_sdo   <= 1'b1;
                        r_bits  <= '0;
                    end
                    BYTE2: if (r_bits == 4'd8) begin
                        r_state <= ACK_2;
                        r_sdo   <= 1'b0;
                    end
                    ACK_2: begin
                        r_state <= IGNORE;
                        r_sdo   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= RST_VAL[i];
        end else if (w_commit) begin
`ifdef WM8731_SOFT_RESET_REG_EN
            if (w_waddr == 7'h0F) for (int i = 0; i < 16; i++) r_regs[i] <= RST_VAL[i];
            else if (w_wimpl) r_regs[w_waddr[3:0]] <= w_wdata;
`else
            if (w_wimpl) r_regs[w_waddr[3:0]] <= w_wdata;
`endif
        end
    end

    assign rd_data  = w_rimpl ? r_regs[rd_addr] : 9'h000;
    assign SDO      = r_sdo;
    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// tb_wm8731_i2c_responder: table vectors, random transactions against a transaction-level model,
// and hand-written repeated-START, glitch, soft-reset and mid-transaction reset sequences.
module tb_wm8731_i2c_responder;
    localparam int H = 12;

    typedef struct {
        logic [31:0] b;
        int          n;
        logic [3:0]  acks;
        logic        commit;
        logic [6:0]  a;
        logic [8:0]  d;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, scl, m_sda, sda_line, sdo, wr_valid, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr;
    int         n_cmp = 0, n_bad = 0, n_wr = 0;
    logic       sdo_q = 1'b1;
    int         exp_regs [16];
    int         rv [16] = '{'h097, 'h097, 'h079, 'h079, 'h00A, 'h008, 'h09F, 'h00A, 0, 0, 0, 0, 0, 0, 0, 0};
    vec_t       tbl [8];
    logic [3:0] m_acks;
    logic       m_commit, a;
    logic [6:0] m_a;
    logic [8:0] m_d;
    logic [31:0] rb;
    int         rn, w0;
    logic [7:0] b1;

    always #5 clk = ~clk;
    assign sda_line = m_sda & sdo;

    wm8731_i2c_responder dut (
        .CLOCK_50(clk), .RESET(rst), .I2C_SCLK(scl), .I2C_SDAT_IN(sda_line), .SDO(sdo),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy)
    );

    always @(negedge clk) if (wr_valid) n_wr++;

    // the responder must never move SDA while the initiator holds SCL high
    always @(negedge clk) begin
        if (sdo !== sdo_q) begin
            n_cmp++;
            if (scl) begin
                n_bad++;
                $display("FAIL sdo_stable: SDO changed to %b while SCL high", sdo);
            end
        end
        sdo_q <= sdo;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic hw();
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hw();
        scl = 1'b1; hw();
        m_sda = 1'b0; hw();
        scl = 1'b0; hw();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hw();
        scl = 1'b1; hw();
        m_sda = 1'b1; hw();
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            if (i == glitch) begin
                repeat (H / 2) @(posedge clk);
                #1 scl = 1'b1;
                repeat (2) @(posedge clk);
                #1 scl = 1'b0;
            end
            hw(); scl = 1'b1; hw(); scl = 1'b0;
        end
        m_sda = 1'b1; hw(); scl = 1'b1;
        repeat (H / 2) @(posedge clk);
        #1 ack = ~sda_line;
        repeat (H / 2) @(posedge clk);
        #1 scl = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_regs[i] = rv[i];
    endtask

    task automatic model_write(input logic [6:0] ad, input logic [8:0] d);
`ifdef WM8731_SOFT_RESET_REG_EN
        if (ad == 7'h0F) begin
            model_reset();
            return;
        end
`endif
        if (ad <= 7'd9 || ad == 7'd15) exp_regs[ad[3:0]] = int'(d);
    endtask

    // transaction-level view: address byte decides everything, commit needs a full third byte
    task automatic model_xfer(input logic [31:0] bs, input int n, output logic [3:0] acks,
                              output logic commit, output logic [6:0] ad, output logic [8:0] d);
        logic ok;
        ok = bs[31:24] == {7'h1A, 1'b0};
        acks = '0;
        for (int k = 0; k < 3; k++) if (ok && k < n) acks[k] = 1'b1;
        commit = ok && n >= 3;
        ad = bs[23:17];
        d = {bs[16], bs[15:8]};
        if (commit) model_write(ad, d);
    endtask

    task automatic run_xfer(input string nm, input logic [31:0] bs, input int n,
                            input logic [3:0] ea, input logic ec, input logic [6:0] ead, input logic [8:0] ed);
        logic [3:0] got;
        logic ak;
        int w;
        w = n_wr;
        got = '0;
        i2c_start();
        chk({nm, ".busy"}, busy, 1'b1);
        for (int k = 0; k < n; k++) begin
            send_byte(bs[31 - 8 * k -: 8], -1, ak);
            got[k] = ak;
        end
        i2c_stop();
        hw();
        chk({nm, ".acks"}, got, ea);
        chk({nm, ".commits"}, n_wr - w, ec ? 1 : 0);
        chk({nm, ".idle"}, busy, 1'b0);
        if (ec) begin
            chk({nm, ".wr_addr"}, wr_addr, ead);
            chk({nm, ".wr_data"}, wr_data, ed);
        end
    endtask

    task automatic check_regs(input string nm);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1 chk($sformatf("%s.R%0d", nm, i), rd_data, exp_regs[i]);
        end
    endtask

    initial begin
        tbl[0] = '{b: 32'h340C0000, n: 3, acks: 4'b0111, commit: 1'b1, a: 7'h06, d: 9'h000};
        tbl[1] = '{b: 32'h360C0000, n: 3, acks: 4'b0000, commit: 1'b0, a: 7'h00, d: 9'h000};
        tbl[2] = '{b: 32'h350C0000, n: 3, acks: 4'b0000, commit: 1'b0, a: 7'h00, d: 9'h000};
        tbl[3] = '{b: 32'h340855AA, n: 4, acks: 4'b0111, commit: 1'b1, a: 7'h04, d: 9'h055};
        tbl[4] = '{b: 32'h34152300, n: 3, acks: 4'b0111, commit: 1'b1, a: 7'h0A, d: 9'h123};
        tbl[5] = '{b: 32'h3403FF00, n: 3, acks: 4'b0111, commit: 1'b1, a: 7'h01, d: 9'h1FF};
        tbl[6] = '{b: 32'h340C0000, n: 2, acks: 4'b0011, commit: 1'b0, a: 7'h00, d: 9'h000};
        tbl[7] = '{b: 32'h34000000, n: 1, acks: 4'b0001, commit: 1'b0, a: 7'h00, d: 9'h000};
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1; rd_addr = '0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("rst.sdo", sdo, 1'b1);
        chk("rst.busy", busy, 1'b0);
        chk("rst.wr_valid", wr_valid, 1'b0);
        chk("rst.wr_addr", wr_addr, 7'h00);
        chk("rst.wr_data", wr_data, 9'h000);
        rst = 1'b0;
        hw();
        check_regs("rst");

        for (int v = 0; v < 8; v++) begin
            if (tbl[v].commit) model_write(tbl[v].a, tbl[v].d);
            run_xfer($sformatf("vec%0d", v), tbl[v].b, tbl[v].n, tbl[v].acks, tbl[v].commit, tbl[v].a, tbl[v].d);
        end
        check_regs("vec");

        for (int t = 0; t < 30; t++) begin
            rb[31:24] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
            rb[23:16] = ($urandom_range(0, 4) != 0) ? {3'b000, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))}
                                                    : 8'($urandom_range(0, 255));
            rb[15:0] = 16'($urandom_range(0, 65535));
            rn = $urandom_range(1, 4);
            model_xfer(rb, rn, m_acks, m_commit, m_a, m_d);
            run_xfer($sformatf("rnd%0d", t), rb, rn, m_acks, m_commit, m_a, m_d);
        end
        check_regs("rnd");

        w0 = n_wr;
        i2c_start();
        send_byte(8'h34, -1, a);
        send_byte(8'h08, -1, a);
        i2c_start();
        send_byte(8'h34, -1, a);
        send_byte(8'h09, -1, a);
        send_byte(8'h55, -1, a);
        i2c_stop();
        hw();
        chk("rstart.commits", n_wr - w0, 1);
        chk("rstart.wr_addr", wr_addr, 7'h04);
        chk("rstart.wr_data", wr_data, 9'h155);
        model_write(7'h04, 9'h155);
        rd_addr = 4'd4;
        #1 chk("rstart.R4", rd_data, 9'h155);

        w0 = n_wr;
        i2c_start();
        send_byte(8'h34, -1, a);
        send_byte(8'h0B, 3, a);
        chk("glitch.ack1", a, 1'b1);
        send_byte(8'h5A, -1, a);
        i2c_stop();
        hw();
        chk("glitch.commits", n_wr - w0, 1);
        model_write(7'h05, 9'h15A);
        rd_addr = 4'd5;
        #1 chk("glitch.R5", rd_data, 9'h15A);

        model_write(7'h04, 9'h1FF);
        run_xfer("r4", 32'h3409FF00, 3, 4'b0111, 1'b1, 7'h04, 9'h1FF);
        rd_addr = 4'd4;
        #1 chk("r4.R4", rd_data, 9'h1FF);
        model_write(7'h0F, 9'h000);
        run_xfer("r15", 32'h341E0000, 3, 4'b0111, 1'b1, 7'h0F, 9'h000);
`ifdef WM8731_SOFT_RESET_REG_EN
        #1 chk("soft.R4", rd_data, 9'h00A);
`else
        #1 chk("soft.R4", rd_data, 9'h1FF);
`endif
        rd_addr = 4'd15;
        #1 chk("soft.R15", rd_data, 9'h000);
        check_regs("soft");

        w0 = n_wr;
        b1 = 8'h02;
        i2c_start();
        send_byte(8'h34, -1, a);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b1[i]; hw(); scl = 1'b1; hw(); scl = 1'b0;
        end
        m_sda = 1'b1;
        hw();
        chk("ack1.sdo", sdo, 1'b0);
        chk("ack1.busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.sdo", sdo, 1'b1);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.wr_addr", wr_addr, 7'h00);
        rst = 1'b0;
        model_reset();
        hw(); scl = 1'b1; hw(); hw();
        chk("midrst.commits", n_wr - w0, 0);
        chk("midrst.idle", busy, 1'b0);
        rd_addr = 4'd0;
        #1 chk("midrst.R0", rd_data, 9'h097);
        check_regs("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
